uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit half of the monitor UART: byte FIFO feeding an 8N1 serializer,
// with full/overrun/underrun status for the loopback block.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV = 234,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_wdata,
    input  logic       tx_wten,
    input  logic       err_clr,
    output logic       tx_fifo_full,
    output logic       tx_fifo_overrun,
    output logic       tx_fifo_underrun,
    output logic       tx_busy,
    output logic       uart_tx
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned CNT_W  = FIFO_AW + 1;
    localparam int unsigned BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    state_t             state;
    logic [7:0]         shift;
    logic [2:0]         bit_idx;
    logic [BAUD_W-1:0]  baud;
    logic               underrun_evt;
    logic               bit_end;
    logic               push;
    logic               pop;

    // Write acceptance uses the registered full flag, so a write on a pop cycle
    // while full is still dropped.
    always_comb begin
        bit_end   = (baud == BAUD_W'(CLK_DIV - 1));
        push      = tx_wten & ~tx_fifo_full;
        pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wptr] <= tx_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            tx_fifo_full     <= 1'b0;
            tx_fifo_overrun  <= 1'b0;
            tx_fifo_underrun <= 1'b0;
            underrun_evt     <= 1'b0;
            state            <= IDLE;
            shift            <= '0;
            bit_idx          <= '0;
            baud             <= '0;
            tx_busy          <= 1'b0;
            uart_tx          <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + FIFO_AW'(1);
            end
            if (pop) begin
                rptr <= rptr + FIFO_AW'(1);
            end
            count        <= count_nxt;
            tx_fifo_full <= (count_nxt == CNT_W'(DEPTH));

            // Sticky flags: a set event in the same cycle as err_clr wins.
            if (tx_wten && tx_fifo_full) begin
                tx_fifo_overrun <= 1'b1;
            end else if (err_clr) begin
                tx_fifo_overrun <= 1'b0;
            end
            if (underrun_evt) begin
                tx_fifo_underrun <= 1'b1;
            end else if (err_clr) begin
                tx_fifo_underrun <= 1'b0;
            end
            underrun_evt <= 1'b0;

            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shift   <= mem[rptr];
                        bit_idx <= '0;
                        baud    <= '0;
                        state   <= START;
                        uart_tx <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud  <= '0;
                        shift <= 8'(shift >> 1);
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (pop) begin
                            shift   <= mem[rptr];
                            bit_idx <= '0;
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state        <= IDLE;
                            tx_busy      <= 1'b0;
                            underrun_evt <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: main instance at CLK_DIV=4/depth 4,
// second instance at CLK_DIV=2 for the divider check.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] tx_wdata;
    logic       tx_wten;
    logic       err_clr;
    logic       tx_fifo_full;
    logic       tx_fifo_overrun;
    logic       tx_fifo_underrun;
    logic       tx_busy;
    logic       uart_tx;

    logic [7:0] b_wdata;
    logic       b_wten;
    logic       b_err_clr;
    logic       b_full;
    logic       b_overrun;
    logic       b_underrun;
    logic       b_busy;
    logic       b_tx;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo #(.CLK_DIV(4), .FIFO_AW(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_wdata         (tx_wdata),
        .tx_wten          (tx_wten),
        .err_clr          (err_clr),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_overrun  (tx_fifo_overrun),
        .tx_fifo_underrun (tx_fifo_underrun),
        .tx_busy          (tx_busy),
        .uart_tx          (uart_tx)
    );

    uart_tx_fifo #(.CLK_DIV(2), .FIFO_AW(2)) dut_div2 (
        .clk              (clk),
        .rst              (rst),
        .tx_wdata         (b_wdata),
        .tx_wten          (b_wten),
        .err_clr          (b_err_clr),
        .tx_fifo_full     (b_full),
        .tx_fifo_overrun  (b_overrun),
        .tx_fifo_underrun (b_underrun),
        .tx_busy          (b_busy),
        .uart_tx          (b_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level for frame bit position idx: start, D0..D7, stop.
    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Called on the first start-bit cycle; returns on the cycle after the stop bit.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        for (int k = 0; k < 40; k++) begin
            check(tag, 32'(uart_tx), 32'(fbit(b, k / 4)));
            if (k < 39) check({tag, "_busy"}, 32'(tx_busy), 32'd1);
            tick();
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] bb;
        rst = 1'b1; tx_wdata = '0; tx_wten = 1'b0; err_clr = 1'b0;
        b_wdata = '0; b_wten = 1'b0; b_err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_full", 32'(tx_fifo_full), 32'd0);
        check("rst_ovr", 32'(tx_fifo_overrun), 32'd0);
        check("rst_unr", 32'(tx_fifo_underrun), 32'd0);
        check("rst_tx2", 32'(b_tx), 32'd1);

        // Single byte: write at T, start bit at T+2, idle at T+42, underrun at T+43.
        tx_wdata = 8'h55; tx_wten = 1'b1;
        tick();
        tx_wten = 1'b0;
        check("single_t1_tx", 32'(uart_tx), 32'd1);
        check("single_t1_busy", 32'(tx_busy), 32'd0);
        tick();
        expect_frame(8'h55, "single_line");
        check("single_idle_tx", 32'(uart_tx), 32'd1);
        check("single_idle_busy", 32'(tx_busy), 32'd0);
        check("single_unr_early", 32'(tx_fifo_underrun), 32'd0);
        tick();
        check("single_unr", 32'(tx_fifo_underrun), 32'd1);
        clear_errs();
        check("clr_unr", 32'(tx_fifo_underrun), 32'd0);

        // Burst A1..A6: A6 dropped, A1..A5 back-to-back.
        for (int i = 0; i < 6; i++) begin
            tx_wdata = 8'(8'hA1 + i); tx_wten = 1'b1;
            tick();
        end
        tx_wten = 1'b0;
        check("burst_full", 32'(tx_fifo_full), 32'd1);
        check("burst_ovr", 32'(tx_fifo_overrun), 32'd1);
        for (int k = 4; k < 200; k++) begin
            bb = 8'(8'hA1 + k / 40);
            check("burst_line", 32'(uart_tx), 32'(fbit(bb, (k % 40) / 4)));
            if (k == 39) check("burst_full_hold", 32'(tx_fifo_full), 32'd1);
            if (k == 40) check("burst_full_fall", 32'(tx_fifo_full), 32'd0);
            tick();
        end
        check("burst_idle_tx", 32'(uart_tx), 32'd1);
        check("burst_idle_busy", 32'(tx_busy), 32'd0);
        tick();
        clear_errs();
        check("burst_clr_ovr", 32'(tx_fifo_overrun), 32'd0);

        // Write on the STOP->START pop cycle while full is dropped; next one lands.
        for (int i = 0; i < 5; i++) begin
            tx_wdata = 8'(8'hB0 + i); tx_wten = 1'b1;
            tick();
        end
        tx_wten = 1'b0;
        check("sim_full", 32'(tx_fifo_full), 32'd1);
        check("sim_ovr0", 32'(tx_fifo_overrun), 32'd0);
        for (int i = 0; i < 36; i++) tick();
        tx_wdata = 8'hC0; tx_wten = 1'b1;
        tick();
        check("sim_ovr", 32'(tx_fifo_overrun), 32'd1);
        check("sim_full_fall", 32'(tx_fifo_full), 32'd0);
        check("sim_next_start", 32'(uart_tx), 32'd0);
        tx_wdata = 8'hC1;
        tick();
        tx_wten = 1'b0;
        check("sim_full_again", 32'(tx_fifo_full), 32'd1);
        for (int i = 0; i < 159; i++) tick();
        expect_frame(8'hC1, "sim_last");
        check("sim_idle_tx", 32'(uart_tx), 32'd1);
        check("sim_idle_busy", 32'(tx_busy), 32'd0);
        tick();
        clear_errs();

        // Reset during DATA bit 3 of 0x0F, with a write in the reset cycle.
        tx_wdata = 8'h0F; tx_wten = 1'b1;
        tick();
        tx_wten = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) tick();
        check("rmid_bit3", 32'(uart_tx), 32'd1);
        check("rmid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1; tx_wten = 1'b1; tx_wdata = 8'hAA;
        tick();
        rst = 1'b0; tx_wten = 1'b0;
        check("rmid_tx", 32'(uart_tx), 32'd1);
        check("rmid_busy0", 32'(tx_busy), 32'd0);
        check("rmid_full", 32'(tx_fifo_full), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rmid_quiet_tx", 32'(uart_tx), 32'd1);
            check("rmid_quiet_busy", 32'(tx_busy), 32'd0);
        end
        tx_wdata = 8'h3C; tx_wten = 1'b1;
        tick();
        tx_wten = 1'b0;
        tick();
        expect_frame(8'h3C, "rmid_3c");
        check("rmid_idle", 32'(uart_tx), 32'd1);
        tick();
        check("rmid_unr", 32'(tx_fifo_underrun), 32'd1);

        // Error clear, then clear colliding with a write-while-full.
        clear_errs();
        check("eclr_unr", 32'(tx_fifo_underrun), 32'd0);
        check("eclr_ovr", 32'(tx_fifo_overrun), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tx_wdata = 8'(8'hE0 + i); tx_wten = 1'b1;
            tick();
        end
        check("eclr_full", 32'(tx_fifo_full), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; tx_wten = 1'b0;
        check("eclr_set_wins", 32'(tx_fifo_overrun), 32'd1);
        clear_errs();
        check("eclr_ovr_cleared", 32'(tx_fifo_overrun), 32'd0);

        // Divider check on the CLK_DIV=2 instance with 0xFF.
        b_wdata = 8'hFF; b_wten = 1'b1;
        tick();
        b_wten = 1'b0;
        check("div2_pre", 32'(b_tx), 32'd1);
        tick();
        for (int k = 0; k < 20; k++) begin
            check("div2_line", 32'(b_tx), (k < 2) ? 32'd0 : 32'd1);
            check("div2_busy", 32'(b_busy), 32'd1);
            tick();
        end
        check("div2_idle_busy", 32'(b_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
